// File: rtl/cdb_pkg.sv
// ----------------------------------------------------------------------------
// cdb_pkg : shared types and round-robin helper for the CDB arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

`ifndef ROB_QUEUE_BITS
`define ROB_QUEUE_BITS 6
`endif

package cdb_pkg;

  localparam int CDB_UID_BITS = `ROB_QUEUE_BITS;
  localparam int VAL_BITS     = 16;
  localparam int LOC_BITS     = 18;
  localparam int MAX_SRC      = 8;

  typedef struct packed {
    logic [CDB_UID_BITS-1:0] uid;
    logic [VAL_BITS-1:0]     val;
    logic [LOC_BITS-1:0]     loc;
  } cdb_entry_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First requester found scanning ptr, ptr+1, ... modulo n (n <= MAX_SRC).
  function automatic rr_pick_t rr_pick(input logic [7:0] req,
                                       input logic [2:0] ptr,
                                       input int         n);
    rr_pick_t   r;
    logic [2:0] k3;
    r = '0;
    for (int i = 0; i < MAX_SRC; i++) begin
      k3 = 3'((int'(ptr) + i) % n);
      if ((i < n) && !r.found && req[k3]) begin
        r.found = 1'b1;
        r.idx   = k3;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cdb_src_fifo.sv
// ----------------------------------------------------------------------------
// cdb_src_fifo : small per-source result FIFO with synchronous flush
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cdb_src_fifo #(
  parameter int BUF_DEPTH = 2,
  parameter int WIDTH     = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] entry_in,
  input  logic             pop,
  output logic [WIDTH-1:0] entry_out,
  output logic             empty,
  output logic             full
);

  localparam int PTR_BITS = $clog2(BUF_DEPTH);
  localparam logic [PTR_BITS:0] FULL_CNT = (PTR_BITS+1)'(BUF_DEPTH);

  logic [WIDTH-1:0]    mem_q [BUF_DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= entry_in;
  end

  assign entry_out = mem_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ----------------------------------------------------------------------------
// cdb_arbiter : buffers functional-unit results and grants the CDB round-robin
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int BUF_DEPTH = 2,
  parameter int UID_BITS  = CDB_UID_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [N_SRC-1:0]           src_valid,
  input  logic [N_SRC*UID_BITS-1:0]  src_uid,
  input  logic [N_SRC*VAL_BITS-1:0]  src_val,
  input  logic [N_SRC*LOC_BITS-1:0]  src_loc,
  output logic [N_SRC-1:0]           src_ready,
  output logic                       cdb_valid,
  input  logic                       cdb_ready,
  output logic [UID_BITS-1:0]        cdb_uid,
  output logic [VAL_BITS-1:0]        cdb_val,
  output logic [LOC_BITS-1:0]        cdb_loc,
  output logic [$clog2(N_SRC)-1:0]   cdb_src,
  output logic                       err_overflow
);

  localparam int SRC_BITS = $clog2(N_SRC);
  localparam int ENTRY_W  = UID_BITS + VAL_BITS + LOC_BITS;

  logic [N_SRC-1:0]   push, pop, empty, full;
  logic [ENTRY_W-1:0] fifo_out [N_SRC];

  generate
    for (genvar i = 0; i < N_SRC; i++) begin : g_src
      logic [ENTRY_W-1:0] fifo_in;
      assign fifo_in = {src_uid[i*UID_BITS +: UID_BITS],
                        src_val[i*VAL_BITS +: VAL_BITS],
                        src_loc[i*LOC_BITS +: LOC_BITS]};

      cdb_src_fifo #(
        .BUF_DEPTH (BUF_DEPTH),
        .WIDTH     (ENTRY_W)
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push[i]),
        .entry_in  (fifo_in),
        .pop       (pop[i]),
        .entry_out (fifo_out[i]),
        .empty     (empty[i]),
        .full      (full[i])
      );
    end
  endgenerate

  // Ready is purely from registered occupancy; a same-cycle pop never raises it.
  assign src_ready = ~full & {N_SRC{~rst}};
  assign push      = src_valid & src_ready & {N_SRC{~flush}};

  logic                cdb_valid_q, cdb_valid_d;
  logic [UID_BITS-1:0] cdb_uid_q, cdb_uid_d;
  logic [VAL_BITS-1:0] cdb_val_q, cdb_val_d;
  logic [LOC_BITS-1:0] cdb_loc_q, cdb_loc_d;
  logic [SRC_BITS-1:0] cdb_src_q, cdb_src_d;
  logic [SRC_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic                err_q, err_d;

  rr_pick_t            pick;
  logic [SRC_BITS-1:0] winner;
  logic [ENTRY_W-1:0]  win_entry;
  logic                load;

  assign pick      = rr_pick(8'(~empty), 3'(rr_ptr_q), N_SRC);
  assign winner    = SRC_BITS'(pick.idx);
  assign win_entry = fifo_out[winner];
  assign load      = (~cdb_valid_q | cdb_ready) & ~flush;

  always_comb begin
    cdb_valid_d = cdb_valid_q;
    cdb_uid_d   = cdb_uid_q;
    cdb_val_d   = cdb_val_q;
    cdb_loc_d   = cdb_loc_q;
    cdb_src_d   = cdb_src_q;
    rr_ptr_d    = rr_ptr_q;
    pop         = '0;
    err_d       = err_q | ((|(src_valid & ~src_ready)) & ~flush);

    if (flush) begin
      cdb_valid_d = 1'b0;
    end else if (load) begin
      if (pick.found) begin
        cdb_valid_d = 1'b1;
        cdb_uid_d   = win_entry[ENTRY_W-1 -: UID_BITS];
        cdb_val_d   = win_entry[LOC_BITS +: VAL_BITS];
        cdb_loc_d   = win_entry[LOC_BITS-1:0];
        cdb_src_d   = winner;
        pop[winner] = 1'b1;
        rr_ptr_d    = (winner == SRC_BITS'(N_SRC-1)) ? '0 : winner + 1'b1;
      end else begin
        cdb_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid_q <= 1'b0;
      cdb_uid_q   <= '0;
      cdb_val_q   <= '0;
      cdb_loc_q   <= '0;
      cdb_src_q   <= '0;
      rr_ptr_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_uid_q   <= cdb_uid_d;
      cdb_val_q   <= cdb_val_d;
      cdb_loc_q   <= cdb_loc_d;
      cdb_src_q   <= cdb_src_d;
      rr_ptr_q    <= rr_ptr_d;
      err_q       <= err_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_uid      = cdb_uid_q;
  assign cdb_val      = cdb_val_q;
  assign cdb_loc      = cdb_loc_q;
  assign cdb_src      = cdb_src_q;
  assign err_overflow = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cdb_arbiter : directed vector bench for cdb_arbiter (4 sources, depth 2)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N = 4;
  localparam int U = CDB_UID_BITS;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            flush = 1'b0;
  logic [N-1:0]    src_valid = '0;
  logic [N*U-1:0]  src_uid = '0;
  logic [N*16-1:0] src_val = '0;
  logic [N*18-1:0] src_loc = '0;
  logic [N-1:0]    src_ready;
  logic            cdb_valid;
  logic            cdb_ready = 1'b1;
  logic [U-1:0]    cdb_uid;
  logic [15:0]     cdb_val;
  logic [17:0]     cdb_loc;
  logic [1:0]      cdb_src;
  logic            err_overflow;

  int checks = 0;
  int failures = 0;

  cdb_arbiter #(.N_SRC(N), .BUF_DEPTH(2), .UID_BITS(U)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .src_valid    (src_valid),
    .src_uid      (src_uid),
    .src_val      (src_val),
    .src_loc      (src_loc),
    .src_ready    (src_ready),
    .cdb_valid    (cdb_valid),
    .cdb_ready    (cdb_ready),
    .cdb_uid      (cdb_uid),
    .cdb_val      (cdb_val),
    .cdb_loc      (cdb_loc),
    .cdb_src      (cdb_src),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rf;    // reset before this row
    logic [3:0]  v;
    logic [23:0] uids;
    logic        rdy;
    logic        ev;
    logic [1:0]  es;
    logic [5:0]  eu;
    logic [3:0]  erdy;
    logic        eerr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] f_val(input logic [5:0] u);
    return {u, 10'h3C5};
  endfunction

  function automatic logic [17:0] f_loc(input logic [5:0] u);
    return {u, 12'h9A1};
  endfunction

  function automatic logic [23:0] pk(input logic [5:0] a0, input logic [5:0] a1,
                                     input logic [5:0] a2, input logic [5:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input logic rf, input logic [3:0] v, input logic [23:0] uids,
                              input logic rdy, input logic ev, input logic [1:0] es,
                              input logic [5:0] eu, input logic [3:0] erdy, input logic eerr);
    vec_t r;
    r.rf = rf; r.v = v; r.uids = uids; r.rdy = rdy; r.ev = ev;
    r.es = es; r.eu = eu; r.erdy = erdy; r.eerr = eerr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [23:0] uids, input logic rdy,
                       input logic fl);
    src_valid = v;
    src_uid   = uids;
    cdb_ready = rdy;
    flush     = fl;
    for (int i = 0; i < N; i++) begin
      src_val[i*16 +: 16] = f_val(uids[i*6 +: 6]);
      src_loc[i*18 +: 18] = f_loc(uids[i*6 +: 6]);
    end
  endtask

  task automatic do_reset();
    drive(4'b0, 24'b0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_ready_low", 64'(src_ready), 64'h0);
    step();
    step();
    chk("rst_valid", 64'(cdb_valid), 64'h0);
    chk("rst_data", {cdb_uid, cdb_val, cdb_loc, cdb_src}, 64'h0);
    chk("rst_err", 64'(err_overflow), 64'h0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 64'(src_ready), 64'hF);
  endtask

  initial begin
    #2;

    // Single result from source 2 with explicit payload
    do_reset();
    src_valid = 4'b0100;
    src_uid   = {6'd0, 6'd5, 6'd0, 6'd0};
    src_val   = {16'h0, 16'hAB12, 32'h0};
    src_loc   = {18'h0, 18'h00034, 36'h0};
    step();
    chk("t1_not_yet", 64'(cdb_valid), 64'h0);
    src_valid = 4'b0;
    step();
    chk("t1_valid", 64'(cdb_valid), 64'h1);
    chk("t1_src", 64'(cdb_src), 64'h2);
    chk("t1_uid", 64'(cdb_uid), 64'h5);
    chk("t1_val", 64'(cdb_val), 64'hAB12);
    chk("t1_loc", 64'(cdb_loc), 64'h34);
    step();
    chk("t1_drop", 64'(cdb_valid), 64'h0);

    // All four sources at once, then a probe of rr_ptr via sources 1 and 3
    vecs.push_back(mk(1, 4'b1111, pk(1, 2, 3, 4), 1, 0, 0, 0, 4'hF, 0));
    vecs.push_back(mk(0, 4'b0000, 24'h0,         1, 1, 0, 1, 4'hF, 0));
    vecs.push_back(mk(0, 4'b0000, 24'h0,         1, 1, 1, 2, 4'hF, 0));
    vecs.push_back(mk(0, 4'b0000, 24'h0,         1, 1, 2, 3, 4'hF, 0));
    vecs.push_back(mk(0, 4'b0000, 24'h0,         1, 1, 3, 4, 4'hF, 0));
    vecs.push_back(mk(0, 4'b0000, 24'h0,         1, 0, 0, 0, 4'hF, 0));
    vecs.push_back(mk(0, 4'b1010, pk(0, 9, 0, 8), 1, 0, 0, 0, 4'hF, 0));
    vecs.push_back(mk(0, 4'b0000, 24'h0,         1, 1, 1, 9, 4'hF, 0));
    vecs.push_back(mk(0, 4'b0000, 24'h0,         1, 1, 3, 8, 4'hF, 0));
    vecs.push_back(mk(0, 4'b0000, 24'h0,         1, 0, 0, 0, 4'hF, 0));
    // Backpressure: source 1 fills, overflow drops uid 14
    vecs.push_back(mk(1, 4'b0010, pk(0, 11, 0, 0), 0, 0, 0, 0,  4'hF,    0));
    vecs.push_back(mk(0, 4'b0010, pk(0, 12, 0, 0), 0, 1, 1, 11, 4'hF,    0));
    vecs.push_back(mk(0, 4'b0010, pk(0, 13, 0, 0), 0, 1, 1, 11, 4'b1101, 0));
    vecs.push_back(mk(0, 4'b0010, pk(0, 14, 0, 0), 0, 1, 1, 11, 4'b1101, 1));
    vecs.push_back(mk(0, 4'b0000, 24'h0,           1, 1, 1, 12, 4'hF,    1));
    vecs.push_back(mk(0, 4'b0000, 24'h0,           1, 1, 1, 13, 4'hF,    1));
    vecs.push_back(mk(0, 4'b0000, 24'h0,           1, 0, 0, 0,  4'hF,    1));
    // Source 0 streaming against a single entry on source 3
    vecs.push_back(mk(1, 4'b1001, pk(10, 0, 0, 7), 1, 0, 0, 0,  4'hF,    0));
    vecs.push_back(mk(0, 4'b0001, pk(11, 0, 0, 0), 1, 1, 0, 10, 4'hF,    0));
    vecs.push_back(mk(0, 4'b0001, pk(12, 0, 0, 0), 1, 1, 3, 7,  4'b1110, 0));
    vecs.push_back(mk(0, 4'b0000, 24'h0,           1, 1, 0, 11, 4'hF,    0));
    vecs.push_back(mk(0, 4'b0000, 24'h0,           1, 1, 0, 12, 4'hF,    0));
    vecs.push_back(mk(0, 4'b0000, 24'h0,           1, 0, 0, 0,  4'hF,    0));

    foreach (vecs[k]) begin
      if (vecs[k].rf) do_reset();
      drive(vecs[k].v, vecs[k].uids, vecs[k].rdy, 1'b0);
      step();
      chk($sformatf("v%0d_valid", k), 64'(cdb_valid), 64'(vecs[k].ev));
      if (vecs[k].ev) begin
        chk($sformatf("v%0d_src", k), 64'(cdb_src), 64'(vecs[k].es));
        chk($sformatf("v%0d_uid", k), 64'(cdb_uid), 64'(vecs[k].eu));
        chk($sformatf("v%0d_val", k), 64'(cdb_val), 64'(f_val(vecs[k].eu)));
        chk($sformatf("v%0d_loc", k), 64'(cdb_loc), 64'(f_loc(vecs[k].eu)));
      end
      chk($sformatf("v%0d_ready", k), 64'(src_ready), 64'(vecs[k].erdy));
      chk($sformatf("v%0d_err", k), 64'(err_overflow), 64'(vecs[k].eerr));
    end

    // Flush with a held beat, a full FIFO and inputs in the flush cycle
    do_reset();
    drive(4'b0101, pk(20, 0, 21, 0), 1'b0, 1'b0);
    step();
    chk("fl_pre_valid", 64'(cdb_valid), 64'h0);
    drive(4'b0100, pk(0, 0, 22, 0), 1'b0, 1'b0);
    step();
    chk("fl_held_valid", 64'(cdb_valid), 64'h1);
    chk("fl_held_uid", 64'(cdb_uid), 64'd20);
    chk("fl_full_ready", 64'(src_ready), 64'b1011);
    drive(4'b0101, pk(23, 0, 24, 0), 1'b0, 1'b1);
    step();
    chk("fl_valid", 64'(cdb_valid), 64'h0);
    chk("fl_ready", 64'(src_ready), 64'hF);
    chk("fl_err", 64'(err_overflow), 64'h0);
    drive(4'b0, 24'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("fl_quiet%0d", i), 64'(cdb_valid), 64'h0);
    end

    // Asynchronous reset between edges while results are in flight
    do_reset();
    drive(4'b1111, pk(1, 2, 3, 4), 1'b1, 1'b0);
    step();
    drive(4'b0, 24'h0, 1'b1, 1'b0);
    step();
    chk("ar_pre_valid", 64'(cdb_valid), 64'h1);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_valid_now", 64'(cdb_valid), 64'h0);
    chk("ar_ready_now", 64'(src_ready), 64'h0);
    chk("ar_uid_now", 64'(cdb_uid), 64'h0);
    step();
    chk("ar_ready_hold", 64'(src_ready), 64'h0);
    #2;
    rst = 1'b0;
    step();
    chk("ar_ready_after", 64'(src_ready), 64'hF);
    chk("ar_valid_after", 64'(cdb_valid), 64'h0);
    step();
    chk("ar_lost", 64'(cdb_valid), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
